// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter for NUM_M masters with HLOCK and fixed-length burst protection.
// All arbitration state advances only on HREADY-qualified clock edges.
module ahb_arbiter_rr #(
  parameter int NUM_M = 4,
  parameter int MID_W = 3
) (
  input  logic             H_clk,
  input  logic             H_resetn,
  input  logic [NUM_M-1:0] H_busreq,
  input  logic [NUM_M-1:0] H_lock,
  input  logic [1:0]       H_trans,
  input  logic [2:0]       H_burst,
  input  logic             H_ready,
  output logic [NUM_M-1:0] H_grant,
  output logic [MID_W-1:0] H_master,
  output logic [MID_W-1:0] H_master_data,
  output logic             H_mastlock
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BURST
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  state_t           state_q, state_d;
  logic [MID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [MID_W-1:0] master_q, master_d;
  logic [MID_W-1:0] master_data_q, master_data_d;
  logic             mastlock_q, mastlock_d;

  logic             found_hi, found_lo, any_req;
  logic [MID_W-1:0] idx_hi, idx_lo, win_idx;
  logic             own_req, own_lock, win_lock;
  logic             handover, do_arb, is_fixed_burst, own_handover_pt;
  logic [3:0]       burst_len_m1;

  // Two-pass priority search: indices above rr_ptr come first, then wrap to the rest.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (H_busreq[i]) begin
        if (MID_W'(i) > rr_ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = MID_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = MID_W'(i);
        end
      end
    end
    any_req = found_hi | found_lo;
    win_idx = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    win_lock = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (master_q == MID_W'(i)) begin
        own_req  = H_busreq[i];
        own_lock = H_lock[i];
      end
      if (win_idx == MID_W'(i)) begin
        win_lock = H_lock[i];
      end
    end
  end

  always_comb begin
    is_fixed_burst = (H_trans == TR_NONSEQ) && (H_burst[2:1] != 2'b00);
    case (H_burst[2:1])
      2'b01:   burst_len_m1 = 4'd3;
      2'b10:   burst_len_m1 = 4'd7;
      default: burst_len_m1 = 4'd15;
    endcase
    own_handover_pt = (H_trans == TR_IDLE)
                   || ((H_trans == TR_NONSEQ) && (H_burst == BU_SINGLE))
                   || (((H_trans == TR_NONSEQ) || (H_trans == TR_SEQ))
                       && (H_burst == BU_INCR) && !own_req);
  end

  // Next-state logic; a locked owner at a handover point simply keeps the bus.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    grant_d       = grant_q;
    master_d      = master_q;
    master_data_d = master_data_q;
    mastlock_d    = mastlock_q;
    handover      = 1'b0;
    do_arb        = 1'b0;

    if (H_ready) begin
      master_data_d = master_q;
      mastlock_d    = (state_q == IDLE) ? 1'b0 : own_lock;

      case (state_q)
        IDLE: begin
          do_arb = any_req;
        end
        OWN: begin
          if (is_fixed_burst) begin
            beat_cnt_d = burst_len_m1;
            state_d    = BURST;
          end else begin
            handover = own_handover_pt;
          end
        end
        BURST: begin
          if (H_trans == TR_IDLE) begin
            beat_cnt_d = '0;
            handover   = 1'b1;
          end else if (H_trans == TR_SEQ) begin
            if (beat_cnt_q <= 4'd1) begin
              beat_cnt_d = '0;
              handover   = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q - 4'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (handover) begin
        if (own_lock) begin
          state_d = OWN;
        end else begin
          do_arb = 1'b1;
        end
      end

      if (do_arb) begin
        beat_cnt_d = '0;
        if (any_req) begin
          state_d    = OWN;
          rr_ptr_d   = win_idx;
          master_d   = win_idx;
          mastlock_d = win_lock;
          for (int i = 0; i < NUM_M; i++) begin
            grant_d[i] = (win_idx == MID_W'(i));
          end
        end else begin
          state_d    = IDLE;
          grant_d    = '0;
          mastlock_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= MID_W'(NUM_M - 1);
      beat_cnt_q    <= '0;
      grant_q       <= '0;
      master_q      <= '0;
      master_data_q <= '0;
      mastlock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      grant_q       <= grant_d;
      master_q      <= master_d;
      master_data_q <= master_data_d;
      mastlock_q    <= mastlock_d;
    end
  end

  assign H_grant       = grant_q;
  assign H_master      = master_q;
  assign H_master_data = master_data_q;
  assign H_mastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed self-checking bench for ahb_arbiter_rr with NUM_M=4.
module tb_ahb_arbiter_rr;

  localparam int NUM_M = 4;
  localparam int MID_W = 3;

  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;

  logic             H_clk;
  logic             H_resetn;
  logic [NUM_M-1:0] H_busreq;
  logic [NUM_M-1:0] H_lock;
  logic [1:0]       H_trans;
  logic [2:0]       H_burst;
  logic             H_ready;
  logic [NUM_M-1:0] H_grant;
  logic [MID_W-1:0] H_master;
  logic [MID_W-1:0] H_master_data;
  logic             H_mastlock;

  int checks = 0;
  int errors = 0;

  ahb_arbiter_rr #(.NUM_M(NUM_M), .MID_W(MID_W)) dut (
    .H_clk        (H_clk),
    .H_resetn     (H_resetn),
    .H_busreq     (H_busreq),
    .H_lock       (H_lock),
    .H_trans      (H_trans),
    .H_burst      (H_burst),
    .H_ready      (H_ready),
    .H_grant      (H_grant),
    .H_master     (H_master),
    .H_master_data(H_master_data),
    .H_mastlock   (H_mastlock)
  );

  initial begin
    H_clk = 1'b0;
    forever #5 H_clk = ~H_clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lck,
                               input logic [1:0] tr, input logic [2:0] bu,
                               input logic rdy);
    H_busreq = req;
    H_lock   = lck;
    H_trans  = tr;
    H_burst  = bu;
    H_ready  = rdy;
    @(posedge H_clk);
    #1;
    checkOutput("onehot0", int'($onehot0(H_grant)), 1);
  endtask

  task automatic pulseReset();
    H_resetn = 1'b0;
    #2;
    H_resetn = 1'b1;
  endtask

  initial begin
    H_resetn = 1'b0;
    H_busreq = '0;
    H_lock   = '0;
    H_trans  = 2'b00;
    H_burst  = 3'b000;
    H_ready  = 1'b1;
    #12;
    checkOutput("rst_grant", int'(H_grant), 0);
    checkOutput("rst_master", int'(H_master), 0);
    checkOutput("rst_mdata", int'(H_master_data), 0);
    checkOutput("rst_mlock", int'(H_mastlock), 0);
    H_resetn = 1'b1;

    // Single requester: grant after one edge, data-phase ID one edge later
    applyStimulus(4'b0001, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("t1_grant", int'(H_grant), 'h1);
    checkOutput("t1_master", int'(H_master), 0);
    applyStimulus(4'b0001, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("t1_mdata", int'(H_master_data), 0);

    // All masters requesting: round-robin rotation from a fresh reset
    pulseReset();
    applyStimulus(4'b1111, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("rr0_grant", int'(H_grant), 'h1);
    checkOutput("rr0_master", int'(H_master), 0);
    applyStimulus(4'b1111, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("rr1_grant", int'(H_grant), 'h2);
    checkOutput("rr1_master", int'(H_master), 1);
    applyStimulus(4'b1111, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("rr2_grant", int'(H_grant), 'h4);
    checkOutput("rr2_master", int'(H_master), 2);
    checkOutput("rr2_mdata", int'(H_master_data), 1);
    applyStimulus(4'b1111, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("rr3_grant", int'(H_grant), 'h8);
    checkOutput("rr3_master", int'(H_master), 3);
    applyStimulus(4'b1111, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("rr4_grant", int'(H_grant), 'h1);
    checkOutput("rr4_master", int'(H_master), 0);

    // INCR8 by master 1 while master 2 also requests
    applyStimulus(4'b0110, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("b8_start", int'(H_grant), 'h2);
    applyStimulus(4'b0110, 4'b0000, NS, INCR8, 1'b1);
    checkOutput("b8_beat1", int'(H_grant), 'h2);
    for (int b = 2; b <= 7; b++) begin
      applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
      checkOutput($sformatf("b8_beat%0d", b), int'(H_grant), 'h2);
    end
    applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
    checkOutput("b8_handover", int'(H_grant), 'h4);
    checkOutput("b8_master", int'(H_master), 2);

    // Same burst with a three-cycle wait state at beat 4
    applyStimulus(4'b0010, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("ws_start", int'(H_grant), 'h2);
    applyStimulus(4'b0110, 4'b0000, NS, INCR8, 1'b1);
    applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
    applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b0);
      checkOutput($sformatf("ws_wait%0d", w), int'(H_grant), 'h2);
    end
    for (int b = 4; b <= 7; b++) begin
      applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
      checkOutput($sformatf("ws_beat%0d", b), int'(H_grant), 'h2);
    end
    applyStimulus(4'b0110, 4'b0000, SQ, INCR8, 1'b1);
    checkOutput("ws_handover", int'(H_grant), 'h4);

    // Master 2 locked: keeps the bus until its lock drops
    applyStimulus(4'b1101, 4'b0100, NS, SINGLE, 1'b1);
    checkOutput("lk0_grant", int'(H_grant), 'h4);
    checkOutput("lk0_mlock", int'(H_mastlock), 1);
    applyStimulus(4'b1101, 4'b0100, NS, SINGLE, 1'b1);
    checkOutput("lk1_grant", int'(H_grant), 'h4);
    checkOutput("lk1_mlock", int'(H_mastlock), 1);
    applyStimulus(4'b1101, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("lk2_grant", int'(H_grant), 'h8);
    checkOutput("lk2_mlock", int'(H_mastlock), 0);

    // Master 3 locked WRAP16, asynchronous reset at beat 5
    applyStimulus(4'b1000, 4'b1000, NS, WRAP16, 1'b1);
    for (int b = 2; b <= 5; b++) begin
      applyStimulus(4'b1000, 4'b1000, SQ, WRAP16, 1'b1);
    end
    checkOutput("w16_grant", int'(H_grant), 'h8);
    checkOutput("w16_mlock", int'(H_mastlock), 1);
    #2;
    H_resetn = 1'b0;
    #1;
    checkOutput("arst_grant", int'(H_grant), 0);
    checkOutput("arst_master", int'(H_master), 0);
    checkOutput("arst_mlock", int'(H_mastlock), 0);
    #2;
    H_resetn = 1'b1;
    applyStimulus(4'b1010, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("post_grant", int'(H_grant), 'h2);
    checkOutput("post_master", int'(H_master), 1);

    // No requests at a handover point: back to IDLE, H_master holds last owner
    applyStimulus(4'b0000, 4'b0000, NS, SINGLE, 1'b1);
    checkOutput("idle_grant", int'(H_grant), 0);
    checkOutput("idle_master", int'(H_master), 1);
    checkOutput("idle_mlock", int'(H_mastlock), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
